// File: rtl/axi_lite_arbiter_2to1.sv
// Two-master to one-slave AXI-Lite arbiter: one transaction in flight, round-robin across ports,
// write/read alternation within a port. Optional response timeout under `AXI_LITE_ARB_TIMEOUT_EN.
module axi_lite_arbiter_2to1 #(
  parameter int AXI_WIDTH_ADDR = 32,
  parameter int AXI_WIDTH_DATA = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  // port 0
  input  logic [AXI_WIDTH_ADDR-1:0] s0_axil_awaddr,
  input  logic                      s0_axil_awvalid,
  output logic                      s0_axil_awready,
  input  logic [AXI_WIDTH_DATA-1:0] s0_axil_wdata,
  input  logic                      s0_axil_wvalid,
  output logic                      s0_axil_wready,
  output logic [1:0]                s0_axil_bresp,
  output logic                      s0_axil_bvalid,
  input  logic                      s0_axil_bready,
  input  logic [AXI_WIDTH_ADDR-1:0] s0_axil_araddr,
  input  logic                      s0_axil_arvalid,
  output logic                      s0_axil_arready,
  output logic [AXI_WIDTH_DATA-1:0] s0_axil_rdata,
  output logic [1:0]                s0_axil_rresp,
  output logic                      s0_axil_rvalid,
  input  logic                      s0_axil_rready,
  // port 1
  input  logic [AXI_WIDTH_ADDR-1:0] s1_axil_awaddr,
  input  logic                      s1_axil_awvalid,
  output logic                      s1_axil_awready,
  input  logic [AXI_WIDTH_DATA-1:0] s1_axil_wdata,
  input  logic                      s1_axil_wvalid,
  output logic                      s1_axil_wready,
  output logic [1:0]                s1_axil_bresp,
  output logic                      s1_axil_bvalid,
  input  logic                      s1_axil_bready,
  input  logic [AXI_WIDTH_ADDR-1:0] s1_axil_araddr,
  input  logic                      s1_axil_arvalid,
  output logic                      s1_axil_arready,
  output logic [AXI_WIDTH_DATA-1:0] s1_axil_rdata,
  output logic [1:0]                s1_axil_rresp,
  output logic                      s1_axil_rvalid,
  input  logic                      s1_axil_rready,
  // shared slave
  output logic [AXI_WIDTH_ADDR-1:0] m_axil_awaddr,
  output logic                      m_axil_awvalid,
  input  logic                      m_axil_awready,
  output logic [AXI_WIDTH_DATA-1:0] m_axil_wdata,
  output logic                      m_axil_wvalid,
  input  logic                      m_axil_wready,
  input  logic [1:0]                m_axil_bresp,
  input  logic                      m_axil_bvalid,
  output logic                      m_axil_bready,
  output logic [AXI_WIDTH_ADDR-1:0] m_axil_araddr,
  output logic                      m_axil_arvalid,
  input  logic                      m_axil_arready,
  input  logic [AXI_WIDTH_DATA-1:0] m_axil_rdata,
  input  logic [1:0]                m_axil_rresp,
  input  logic                      m_axil_rvalid,
  output logic                      m_axil_rready,
  output logic                      timeout_err
);

  typedef enum logic [2:0] {IDLE, WR_ADDR, WR_RESP, RD_ADDR, RD_DATA} state_t;

  state_t     state;
  logic       gnt;
  logic       rr_ptr;
  logic [1:0] last_wr;
  logic       aw_done;
  logic       w_done;
  logic       to_flag;
  logic       absorb;

  logic [1:0]                     awvalid, wvalid, arvalid, bready, rready;
  logic [1:0][AXI_WIDTH_ADDR-1:0] awaddr, araddr;
  logic [1:0][AXI_WIDTH_DATA-1:0] wdata;

  assign awvalid = {s1_axil_awvalid, s0_axil_awvalid};
  assign wvalid  = {s1_axil_wvalid,  s0_axil_wvalid};
  assign arvalid = {s1_axil_arvalid, s0_axil_arvalid};
  assign bready  = {s1_axil_bready,  s0_axil_bready};
  assign rready  = {s1_axil_rready,  s0_axil_rready};
  assign awaddr  = {s1_axil_awaddr,  s0_axil_awaddr};
  assign araddr  = {s1_axil_araddr,  s0_axil_araddr};
  assign wdata   = {s1_axil_wdata,   s0_axil_wdata};

  logic st_wa, st_wb, st_ra, st_rd;
  assign st_wa = (state == WR_ADDR);
  assign st_wb = (state == WR_RESP);
  assign st_ra = (state == RD_ADDR);
  assign st_rd = (state == RD_DATA);

  // IDLE arbitration: round-robin only matters when both ports ask
  logic [1:0] req;
  logic       g_sel;
  logic       take_wr;
  assign req     = awvalid | arvalid;
  assign g_sel   = (req[0] & req[1]) ? rr_ptr : req[1];
  assign take_wr = awvalid[g_sel] & (~arvalid[g_sel] | ~last_wr[g_sel]);

  // Master side: AW/W masked once their own handshake has happened
  assign m_axil_awvalid = st_wa & ~aw_done & awvalid[gnt];
  assign m_axil_awaddr  = st_wa ? awaddr[gnt] : '0;
  assign m_axil_wvalid  = st_wa & ~w_done & wvalid[gnt];
  assign m_axil_wdata   = st_wa ? wdata[gnt] : '0;
  assign m_axil_arvalid = st_ra & arvalid[gnt];
  assign m_axil_araddr  = st_ra ? araddr[gnt] : '0;

  logic b_pass, r_pass;
  assign b_pass        = st_wb & ~to_flag;
  assign r_pass        = st_rd & ~to_flag;
  assign m_axil_bready = b_pass ? bready[gnt] : absorb;
  assign m_axil_rready = r_pass ? rready[gnt] : absorb;

  // Port side: response either forwarded or synthesised as SLVERR after a timeout
  logic       sb_valid, sr_valid;
  logic [1:0] sb_resp, sr_resp;
  logic [AXI_WIDTH_DATA-1:0] sr_data;
  assign sb_valid = st_wb & (to_flag | m_axil_bvalid);
  assign sb_resp  = to_flag ? 2'b10 : m_axil_bresp;
  assign sr_valid = st_rd & (to_flag | m_axil_rvalid);
  assign sr_resp  = to_flag ? 2'b10 : m_axil_rresp;
  assign sr_data  = to_flag ? '0 : m_axil_rdata;

  assign s0_axil_awready = st_wa & ~gnt & ~aw_done & m_axil_awready;
  assign s1_axil_awready = st_wa &  gnt & ~aw_done & m_axil_awready;
  assign s0_axil_wready  = st_wa & ~gnt & ~w_done & m_axil_wready;
  assign s1_axil_wready  = st_wa &  gnt & ~w_done & m_axil_wready;
  assign s0_axil_arready = st_ra & ~gnt & m_axil_arready;
  assign s1_axil_arready = st_ra &  gnt & m_axil_arready;

  assign s0_axil_bvalid = sb_valid & ~gnt;
  assign s1_axil_bvalid = sb_valid &  gnt;
  assign s0_axil_bresp  = (st_wb & ~gnt) ? sb_resp : 2'b00;
  assign s1_axil_bresp  = (st_wb &  gnt) ? sb_resp : 2'b00;

  assign s0_axil_rvalid = sr_valid & ~gnt;
  assign s1_axil_rvalid = sr_valid &  gnt;
  assign s0_axil_rresp  = (st_rd & ~gnt) ? sr_resp : 2'b00;
  assign s1_axil_rresp  = (st_rd &  gnt) ? sr_resp : 2'b00;
  assign s0_axil_rdata  = (st_rd & ~gnt) ? sr_data : '0;
  assign s1_axil_rdata  = (st_rd &  gnt) ? sr_data : '0;

  logic aw_hs, w_hs, ar_hs, b_hs, r_hs;
  assign aw_hs = m_axil_awvalid & m_axil_awready;
  assign w_hs  = m_axil_wvalid & m_axil_wready;
  assign ar_hs = m_axil_arvalid & m_axil_arready;
  assign b_hs  = sb_valid & bready[gnt];
  assign r_hs  = sr_valid & rready[gnt];

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state   <= IDLE;
      gnt     <= 1'b0;
      rr_ptr  <= 1'b0;
      last_wr <= 2'b00;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            gnt   <= g_sel;
            state <= take_wr ? WR_ADDR : RD_ADDR;
          end
        end
        WR_ADDR: begin
          if (aw_hs) aw_done <= 1'b1;
          if (w_hs)  w_done  <= 1'b1;
          if ((aw_done | aw_hs) & (w_done | w_hs)) state <= WR_RESP;
        end
        WR_RESP: begin
          if (b_hs) begin
            state        <= IDLE;
            rr_ptr       <= ~gnt;
            last_wr[gnt] <= 1'b1;
            aw_done      <= 1'b0;
            w_done       <= 1'b0;
          end
        end
        RD_ADDR: begin
          if (ar_hs) state <= RD_DATA;
        end
        RD_DATA: begin
          if (r_hs) begin
            state        <= IDLE;
            rr_ptr       <= ~gnt;
            last_wr[gnt] <= 1'b0;
            aw_done      <= 1'b0;
            w_done       <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef AXI_LITE_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] to_cnt;
  logic             to_err_q;
  logic             in_resp;
  logic             m_resp_seen;

  assign in_resp     = st_wb | st_rd;
  assign m_resp_seen = st_wb ? m_axil_bvalid : m_axil_rvalid;
  assign absorb      = 1'b1;
  assign timeout_err = to_err_q;

  // Counter freezes once the slave responds; flag holds the fake response until accepted
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      to_cnt   <= '0;
      to_flag  <= 1'b0;
      to_err_q <= 1'b0;
    end else begin
      to_err_q <= 1'b0;
      if (!in_resp) begin
        to_cnt  <= '0;
        to_flag <= 1'b0;
      end else if (!to_flag && !m_resp_seen) begin
        if (to_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          to_flag  <= 1'b1;
          to_err_q <= 1'b1;
        end else begin
          to_cnt <= to_cnt + 1'b1;
        end
      end
    end
  end
`else
  assign to_flag     = 1'b0;
  assign absorb      = 1'b0;
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_axi_lite_arbiter_2to1.sv
// Directed bench for axi_lite_arbiter_2to1 with a small behavioural AXI-Lite slave.
module tb_axi_lite_arbiter_2to1;

  logic aclk = 1'b0;
  logic aresetn;
  always #5 aclk = ~aclk;

  logic [31:0] s0_axil_awaddr, s0_axil_wdata, s0_axil_araddr, s0_axil_rdata;
  logic        s0_axil_awvalid, s0_axil_awready, s0_axil_wvalid, s0_axil_wready;
  logic [1:0]  s0_axil_bresp, s0_axil_rresp;
  logic        s0_axil_bvalid, s0_axil_bready, s0_axil_arvalid, s0_axil_arready;
  logic        s0_axil_rvalid, s0_axil_rready;
  logic [31:0] s1_axil_awaddr, s1_axil_wdata, s1_axil_araddr, s1_axil_rdata;
  logic        s1_axil_awvalid, s1_axil_awready, s1_axil_wvalid, s1_axil_wready;
  logic [1:0]  s1_axil_bresp, s1_axil_rresp;
  logic        s1_axil_bvalid, s1_axil_bready, s1_axil_arvalid, s1_axil_arready;
  logic        s1_axil_rvalid, s1_axil_rready;
  logic [31:0] m_axil_awaddr, m_axil_wdata, m_axil_araddr, m_axil_rdata;
  logic        m_axil_awvalid, m_axil_awready, m_axil_wvalid, m_axil_wready;
  logic [1:0]  m_axil_bresp, m_axil_rresp;
  logic        m_axil_bvalid, m_axil_bready, m_axil_arvalid, m_axil_arready;
  logic        m_axil_rvalid, m_axil_rready;
  logic        timeout_err;

`ifdef AXI_LITE_ARB_TIMEOUT_EN
  localparam logic [1:0] EXP_ABSORB = 2'b11;
`else
  localparam logic [1:0] EXP_ABSORB = 2'b00;
`endif

  axi_lite_arbiter_2to1 #(.AXI_WIDTH_ADDR(32), .AXI_WIDTH_DATA(32), .TIMEOUT_CYCLES(8)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s0_axil_awaddr(s0_axil_awaddr), .s0_axil_awvalid(s0_axil_awvalid), .s0_axil_awready(s0_axil_awready),
    .s0_axil_wdata(s0_axil_wdata), .s0_axil_wvalid(s0_axil_wvalid), .s0_axil_wready(s0_axil_wready),
    .s0_axil_bresp(s0_axil_bresp), .s0_axil_bvalid(s0_axil_bvalid), .s0_axil_bready(s0_axil_bready),
    .s0_axil_araddr(s0_axil_araddr), .s0_axil_arvalid(s0_axil_arvalid), .s0_axil_arready(s0_axil_arready),
    .s0_axil_rdata(s0_axil_rdata), .s0_axil_rresp(s0_axil_rresp), .s0_axil_rvalid(s0_axil_rvalid),
    .s0_axil_rready(s0_axil_rready),
    .s1_axil_awaddr(s1_axil_awaddr), .s1_axil_awvalid(s1_axil_awvalid), .s1_axil_awready(s1_axil_awready),
    .s1_axil_wdata(s1_axil_wdata), .s1_axil_wvalid(s1_axil_wvalid), .s1_axil_wready(s1_axil_wready),
    .s1_axil_bresp(s1_axil_bresp), .s1_axil_bvalid(s1_axil_bvalid), .s1_axil_bready(s1_axil_bready),
    .s1_axil_araddr(s1_axil_araddr), .s1_axil_arvalid(s1_axil_arvalid), .s1_axil_arready(s1_axil_arready),
    .s1_axil_rdata(s1_axil_rdata), .s1_axil_rresp(s1_axil_rresp), .s1_axil_rvalid(s1_axil_rvalid),
    .s1_axil_rready(s1_axil_rready),
    .m_axil_awaddr(m_axil_awaddr), .m_axil_awvalid(m_axil_awvalid), .m_axil_awready(m_axil_awready),
    .m_axil_wdata(m_axil_wdata), .m_axil_wvalid(m_axil_wvalid), .m_axil_wready(m_axil_wready),
    .m_axil_bresp(m_axil_bresp), .m_axil_bvalid(m_axil_bvalid), .m_axil_bready(m_axil_bready),
    .m_axil_araddr(m_axil_araddr), .m_axil_arvalid(m_axil_arvalid), .m_axil_arready(m_axil_arready),
    .m_axil_rdata(m_axil_rdata), .m_axil_rresp(m_axil_rresp), .m_axil_rvalid(m_axil_rvalid),
    .m_axil_rready(m_axil_rready),
    .timeout_err(timeout_err)
  );

  // Behavioural slave: always ready, B one cycle after AW+W, R returns the read address
  logic        sl_bvalid, sl_rvalid, have_aw, have_w, mute_b, mute_r, late_rvalid;
  logic [31:0] sl_rdata, sl_awaddr, sl_wdata;
  logic [31:0] ar_log[$];

  assign m_axil_awready = 1'b1;
  assign m_axil_wready  = 1'b1;
  assign m_axil_arready = 1'b1;
  assign m_axil_bresp   = 2'b00;
  assign m_axil_rresp   = 2'b00;
  assign m_axil_bvalid  = sl_bvalid;
  assign m_axil_rvalid  = sl_rvalid | late_rvalid;
  assign m_axil_rdata   = sl_rdata;

  always @(posedge aclk) begin
    if (!aresetn) begin
      sl_bvalid <= 1'b0; sl_rvalid <= 1'b0; have_aw <= 1'b0; have_w <= 1'b0;
      sl_rdata <= '0; sl_awaddr <= '0; sl_wdata <= '0;
    end else begin
      if (sl_bvalid && m_axil_bready) sl_bvalid <= 1'b0;
      if (sl_rvalid && m_axil_rready) sl_rvalid <= 1'b0;
      if (m_axil_awvalid) begin have_aw <= 1'b1; sl_awaddr <= m_axil_awaddr; end
      if (m_axil_wvalid)  begin have_w  <= 1'b1; sl_wdata  <= m_axil_wdata;  end
      if ((have_aw || m_axil_awvalid) && (have_w || m_axil_wvalid)) begin
        have_aw <= 1'b0; have_w <= 1'b0;
        if (!mute_b) sl_bvalid <= 1'b1;
      end
      if (m_axil_arvalid) begin
        ar_log.push_back(m_axil_araddr);
        if (!mute_r) begin sl_rvalid <= 1'b1; sl_rdata <= m_axil_araddr; end
      end
    end
  end

  // Master-side transaction monitor
  int cyc = 0, to_pulses = 0;
  int op_kind[$], op_cyc[$], done_cyc[$];
  always @(posedge aclk) begin
    cyc <= cyc + 1;
    if (m_axil_awvalid && m_axil_awready) begin op_kind.push_back(1); op_cyc.push_back(cyc); end
    if (m_axil_arvalid && m_axil_arready) begin op_kind.push_back(0); op_cyc.push_back(cyc); end
    if (m_axil_bvalid && m_axil_bready) done_cyc.push_back(cyc);
    if (m_axil_rvalid && m_axil_rready) done_cyc.push_back(cyc);
    if (timeout_err) to_pulses <= to_pulses + 1;
  end

  int n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_vr"}, {m_axil_awvalid, m_axil_wvalid, m_axil_arvalid,
                       s0_axil_awready, s0_axil_wready, s0_axil_arready, s0_axil_bvalid, s0_axil_rvalid,
                       s1_axil_awready, s1_axil_wready, s1_axil_arready, s1_axil_bvalid, s1_axil_rvalid}, 0);
    chk({tag, "_mrdy"}, {m_axil_bready, m_axil_rready}, EXP_ABSORB);
    chk({tag, "_data"}, m_axil_awaddr | m_axil_wdata | m_axil_araddr | s0_axil_rdata | s1_axil_rdata, 0);
    chk({tag, "_resp"}, {s0_axil_bresp, s0_axil_rresp, s1_axil_bresp, s1_axil_rresp, 1'b0, timeout_err}, 0);
  endtask

  task automatic rd(input int p, input logic [31:0] addr, output logic [31:0] data,
                    output logic [1:0] resp, output int waits);
    int n;
    @(negedge aclk);
    if (p == 0) begin s0_axil_arvalid = 1'b1; s0_axil_araddr = addr; end
    else        begin s1_axil_arvalid = 1'b1; s1_axil_araddr = addr; end
    #1;
    n = 0;
    while (!(p == 0 ? s0_axil_arready : s1_axil_arready) && n < 100) begin
      @(negedge aclk); #1; n++;
    end
    if (n >= 100) chk("ar_wait_bound", n, 0);
    @(negedge aclk);
    if (p == 0) begin s0_axil_arvalid = 1'b0; s0_axil_rready = 1'b1; end
    else        begin s1_axil_arvalid = 1'b0; s1_axil_rready = 1'b1; end
    #1;
    n = 0;
    while (!(p == 0 ? s0_axil_rvalid : s1_axil_rvalid) && n < 100) begin
      @(negedge aclk); #1; n++;
    end
    if (n >= 100) chk("r_wait_bound", n, 0);
    waits = n;
    data  = (p == 0) ? s0_axil_rdata : s1_axil_rdata;
    resp  = (p == 0) ? s0_axil_rresp : s1_axil_rresp;
    @(negedge aclk);
    if (p == 0) s0_axil_rready = 1'b0; else s1_axil_rready = 1'b0;
  endtask

  logic [31:0] d00, d01, d10, d11, d;
  logic [1:0]  r00, r01, r10, r11, r;
  int w0, w1, w2, w3, w, base_op, base_done, base_ar, base_to, n;

  initial begin
    aresetn = 1'b0;
    {s0_axil_awvalid, s0_axil_wvalid, s0_axil_bready, s0_axil_arvalid, s0_axil_rready} = '0;
    {s1_axil_awvalid, s1_axil_wvalid, s1_axil_bready, s1_axil_arvalid, s1_axil_rready} = '0;
    {s0_axil_awaddr, s0_axil_wdata, s0_axil_araddr} = '0;
    {s1_axil_awaddr, s1_axil_wdata, s1_axil_araddr} = '0;
    mute_b = 1'b0; mute_r = 1'b0; late_rvalid = 1'b0;

    // reset defaults
    repeat (3) @(posedge aclk);
    @(negedge aclk); #1;
    chk_idle("reset");
    aresetn = 1'b1;
    @(negedge aclk); #1;
    chk_idle("post_reset");

    // round-robin reads: first grant s0, then alternation, own address back
    base_ar = ar_log.size();
    fork
      begin rd(0, 32'h100, d00, r00, w0); rd(0, 32'h104, d01, r01, w1); end
      begin rd(1, 32'h200, d10, r10, w2); rd(1, 32'h204, d11, r11, w3); end
    join
    chk("rr_n_ar", ar_log.size() - base_ar, 4);
    if (ar_log.size() >= base_ar + 4) begin
      chk("rr_g0", ar_log[base_ar+0], 32'h100);
      chk("rr_g1", ar_log[base_ar+1], 32'h200);
      chk("rr_g2", ar_log[base_ar+2], 32'h104);
      chk("rr_g3", ar_log[base_ar+3], 32'h204);
    end
    chk("rr_d00", d00, 32'h100);
    chk("rr_d01", d01, 32'h104);
    chk("rr_d10", d10, 32'h200);
    chk("rr_d11", d11, 32'h204);
    chk("rr_resp", {r00, r01, r10, r11}, 0);

    // single write from s0, AW a cycle ahead of W
    @(negedge aclk);
    s0_axil_awvalid = 1'b1; s0_axil_awaddr = 32'h10;
    #1 chk("wr_aw_pre_grant", m_axil_awvalid, 0);
    @(negedge aclk); #1;
    chk("wr_aw_valid", m_axil_awvalid, 1);
    chk("wr_aw_addr", m_axil_awaddr, 32'h10);
    chk("wr_s0_awready", s0_axil_awready, 1);
    chk("wr_m_wvalid_early", m_axil_wvalid, 0);
    chk("wr_s1_ready", {s1_axil_awready, s1_axil_wready, s1_axil_arready}, 0);
    @(negedge aclk);
    s0_axil_awvalid = 1'b0; s0_axil_wvalid = 1'b1; s0_axil_wdata = 32'hA5;
    #1;
    chk("wr_w_valid", m_axil_wvalid, 1);
    chk("wr_w_data", m_axil_wdata, 32'hA5);
    chk("wr_aw_masked", m_axil_awvalid, 0);
    chk("wr_s0_wready", s0_axil_wready, 1);
    @(negedge aclk);
    s0_axil_wvalid = 1'b0; s0_axil_bready = 1'b1;
    #1;
    chk("wr_s0_bvalid", s0_axil_bvalid, 1);
    chk("wr_s0_bresp", s0_axil_bresp, 0);
    chk("wr_s1_bvalid", s1_axil_bvalid, 0);
    @(negedge aclk);
    s0_axil_bready = 1'b0;
    #1;
    chk("wr_done_idle", s0_axil_bvalid, 0);
    chk("wr_sl_addr", sl_awaddr, 32'h10);
    chk("wr_sl_data", sl_wdata, 32'hA5);

    // s1 holds write and read together: write, read, write with one IDLE cycle between
    base_op = op_kind.size(); base_done = done_cyc.size();
    @(negedge aclk);
    s1_axil_awvalid = 1'b1; s1_axil_awaddr = 32'h250; s1_axil_wvalid = 1'b1; s1_axil_wdata = 32'h5A5A;
    s1_axil_arvalid = 1'b1; s1_axil_araddr = 32'h254; s1_axil_bready = 1'b1; s1_axil_rready = 1'b1;
    n = 0;
    while (op_kind.size() < base_op + 3 && n < 200) begin @(negedge aclk); n++; end
    s1_axil_awvalid = 1'b0; s1_axil_wvalid = 1'b0; s1_axil_arvalid = 1'b0;
    n = 0;
    while (done_cyc.size() < base_done + 3 && n < 200) begin @(negedge aclk); n++; end
    s1_axil_bready = 1'b0; s1_axil_rready = 1'b0;
    chk("alt_n_ops", op_kind.size() - base_op, 3);
    chk("alt_n_done", done_cyc.size() - base_done, 3);
    if (op_kind.size() >= base_op + 3 && done_cyc.size() >= base_done + 2) begin
      chk("alt_op0_wr", op_kind[base_op+0], 1);
      chk("alt_op1_rd", op_kind[base_op+1], 0);
      chk("alt_op2_wr", op_kind[base_op+2], 1);
      chk("alt_gap1", op_cyc[base_op+1] - done_cyc[base_done+0], 2);
      chk("alt_gap2", op_cyc[base_op+2] - done_cyc[base_done+1], 2);
    end

`ifdef AXI_LITE_ARB_TIMEOUT_EN
    // read timeout: slave never answers
    repeat (2) @(negedge aclk);
    mute_r = 1'b1;
    base_to = to_pulses;
    rd(0, 32'h40, d, r, w);
    chk("to_wait_cycles", w, 8);
    chk("to_rresp", r, 2'b10);
    chk("to_rdata", d, 0);
    repeat (2) @(negedge aclk);
    chk("to_pulse_once", to_pulses - base_to, 1);
    mute_r = 1'b0;
    @(negedge aclk);
    late_rvalid = 1'b1;
    #1;
    chk("to_late_s_rvalid", {s0_axil_rvalid, s1_axil_rvalid}, 0);
    chk("to_late_m_rready", m_axil_rready, 1);
    @(negedge aclk);
    late_rvalid = 1'b0;
`endif

    // reset while waiting in WR_RESP, then a fresh s1 read
    repeat (2) @(negedge aclk);
    mute_b = 1'b1;
    s0_axil_awvalid = 1'b1; s0_axil_awaddr = 32'h60;
    s0_axil_wvalid = 1'b1; s0_axil_wdata = 32'h77; s0_axil_bready = 1'b1;
    repeat (2) @(negedge aclk);
    s0_axil_awvalid = 1'b0; s0_axil_wvalid = 1'b0;
    #1 chk("rst_mid_no_b", s0_axil_bvalid, 0);
    aresetn = 1'b0;
    @(negedge aclk); #1;
    chk_idle("rst_mid");
    aresetn = 1'b1; mute_b = 1'b0; s0_axil_bready = 1'b0;
    rd(1, 32'h300, d, r, w);
    chk("rst_rd_data", d, 32'h300);
    chk("rst_rd_resp", r, 0);

    repeat (2) @(negedge aclk);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/axi_lite_arbiter_2to1.md
# axi_lite_arbiter_2to1

Two-master to one-slave AXI-Lite arbiter that shares a single AXI-Lite register port, such as the `i2c_axi_lite` slave, between the co-simulation BFM path and a second requester such as the RISC-V core's peripheral bus. It carries exactly one transaction at a time. Arbitration between ports is round-robin, and reads and writes alternate within a port. Handshakes pass through combinationally once a grant is registered.

## Interface
- AXI_WIDTH_ADDR, 32, address width
- AXI_WIDTH_DATA, 32, data width
- TIMEOUT_CYCLES, 1024, response timeout; used only with `AXI_LITE_ARB_TIMEOUT_EN`
- Clock and reset: one clock; reset is synchronous and active-low.

Ports (`sN` = s0 and s1, slave side; `m` = master side):
- aclk  in  1  clock, all logic on rising edge
- aresetn  in  1  synchronous active-low reset
- sN_axil_awaddr / m_axil_awaddr  in / out  AXI_WIDTH_ADDR  write address
- sN_axil_awvalid / m_axil_awvalid  in / out  1  write address valid
- sN_axil_awready / m_axil_awready  out / in  1  write address ready
- sN_axil_wdata / m_axil_wdata  in / out  AXI_WIDTH_DATA  write data
- sN_axil_wvalid / m_axil_wvalid  in / out  1  write data valid
- sN_axil_wready / m_axil_wready  out / in  1  write data ready
- sN_axil_bresp / m_axil_bresp  out / in  2  write response
- sN_axil_bvalid / m_axil_bvalid  out / in  1  write response valid
- sN_axil_bready / m_axil_bready  in / out  1  write response ready
- sN_axil_araddr / m_axil_araddr  in / out  AXI_WIDTH_ADDR  read address
- sN_axil_arvalid / m_axil_arvalid  in / out  1  read address valid
- sN_axil_arready / m_axil_arready  out / in  1  read address ready
- sN_axil_rdata, sN_axil_rresp / m_axil_rdata, m_axil_rresp  out / in  AXI_WIDTH_DATA, 2  read data and response
- sN_axil_rvalid / m_axil_rvalid  out / in  1  read valid
- sN_axil_rready / m_axil_rready  in / out  1  read ready
- timeout_err  out  1  one-cycle pulse on a timeout; tied to 0 without the macro

## Operation
- **States:**
  - IDLE
  - WR_ADDR (AW and W phases)
  - WR_RESP
  - RD_ADDR
  - RD_DATA
- **Registered state:**
  - `gnt`: 1 bit
  - `rr_ptr`: 1 bit, preferred port
  - `last_wr[1:0]`: per-port last operation
  - `aw_done`, `w_done`
- **Requests:** port N requests when `sN_awvalid | sN_arvalid`.
- **IDLE grant:**
  - If both ports request, grant `rr_ptr`; otherwise grant the single requester.
  - Within the granted port: if both awvalid and arvalid are set, take the write when `last_wr[N]==0`, else the read. Otherwise take whichever is valid.
  - Go to WR_ADDR or RD_ADDR.
- **WR_ADDR:**
  - Granted port's AW and W are routed to m.
  - `aw_done` / `w_done` are set on the respective handshakes, and that channel's valid and ready are masked afterwards.
  - When both are done (including the same cycle), go to WR_RESP.
- **WR_RESP:** b channel is routed to the granted port. On the B handshake, go to IDLE.
- **RD_ADDR:** AR is routed to the granted port. On the AR handshake, go to RD_DATA.
- **RD_DATA:** R is routed to the granted port. On the R handshake, go to IDLE.
- **Completion (returning to IDLE):**
  - `rr_ptr <= ~gnt`
  - `last_wr[gnt]` is set to 1 for a write, 0 for a read
  - `aw_done` and `w_done` are cleared
- **Masking:**
  - The ungranted port sees all ready and valid outputs at 0.
  - m valid and ready outputs are 0 in IDLE and in non-matching states.
  - Data and address outputs are muxed by `gnt`; their values do not matter when valid is low.

## Timing
- **Reset:**
  - State IDLE, `rr_ptr=0`, `last_wr=2'b00`, done flags 0.
  - Every valid and ready output is 0; every data and response output is 0.
- **Latency:**
  - The grant is registered, so m valid rises 1 cycle after a request appears in IDLE.
  - Handshakes then pass through with zero added latency.
  - 1 IDLE cycle separates back-to-back transactions.
- **Holding requests:** a request withdrawn by a non-compliant master before its grant is simply not granted. A compliant master holds valid until the handshake.
- **Reset mid-transaction:** everything returns to reset values at the next edge, and the transaction is abandoned. The slave is reset by the same `aresetn`.

## Configuration
- **Macro:** `AXI_LITE_ARB_TIMEOUT_EN`
- **Defined:**
  - A counter runs in WR_RESP and RD_DATA.
  - If `m_bvalid` / `m_rvalid` has not arrived after TIMEOUT_CYCLES cycles, the arbiter drives the granted port itself: `bvalid` or `rvalid` = 1, `resp=2'b10` (SLVERR), `rdata=0`. The response is held until accepted, `timeout_err` pulses, and the state goes to IDLE.
  - Outside WR_RESP and RD_DATA, `m_bready` and `m_rready` are driven to 1 to absorb stray late responses.
- **Undefined:** no counter exists; the arbiter waits indefinitely; `timeout_err=0`; `m_bready` and `m_rready` are 0 outside the response states.

## Test plan
- **Reset defaults:** hold `aresetn=0` for 3 cycles → all valid/ready outputs are 0; first grant after release goes to s0.
- **Single write:** s0 writes addr 0x10, data 0xA5 with AW before W; slave bresp=0 → m sees AW at cycle+1 then W; s0 gets bresp=0; s1 sees no ready.
- **Round-robin:** both ports issue reads every cycle, slave returns addr as data → grants alternate s0, s1, s0, s1; each port gets its own address back.
- **Write/read alternation:** s1 holds awvalid and arvalid simultaneously → write, read, write order; one IDLE cycle between transactions.
- **Timeout:** macro on, TIMEOUT_CYCLES=8, slave never asserts rvalid → after 8 cycles s0 gets rresp=2'b10, rdata=0, and `timeout_err` pulses once. A late `m_rvalid` is absorbed without reaching s0 or s1.
- **Reset mid-write:** drop `aresetn` in WR_RESP → next cycle is IDLE with all outputs 0, and a new s1 read completes normally.
